// File: rtl/icache_fetch_if.sv
// Fetch-side bundle: CPU request/response plus instruction-memory block port.
// slave = cache side, master = CPU/memory environment side.
`timescale 1ns/1ps
interface icache_fetch_if #(
    parameter int ADDR_W = 10
);
    logic [31:0]       PC;
    logic [31:0]       INSTRUCTION;
    logic              BUSYWAIT;
    logic              MEM_READ;
    logic [ADDR_W-5:0] MEM_ADDRESS;
    logic [127:0]      MEM_READDATA;
    logic              MEM_BUSYWAIT;

    modport slave (
        input  PC,
        input  MEM_READDATA,
        input  MEM_BUSYWAIT,
        output INSTRUCTION,
        output BUSYWAIT,
        output MEM_READ,
        output MEM_ADDRESS
    );

    modport master (
        output PC,
        output MEM_READDATA,
        output MEM_BUSYWAIT,
        input  INSTRUCTION,
        input  BUSYWAIT,
        input  MEM_READ,
        input  MEM_ADDRESS
    );
endinterface

// File: rtl/icache_fetch.sv
// Direct-mapped instruction cache: same-cycle hits, miss stalls via BUSYWAIT.
// Ports: CLK, RESET (async active-low), bus (icache_fetch_if.slave).
`timescale 1ns/1ps
module icache_fetch #(
    parameter int ADDR_W   = 10,
    parameter int N_BLOCKS = 8
) (
    input  logic          CLK,
    input  logic          RESET,
    icache_fetch_if.slave bus
);
    localparam int IDX_W = $clog2(N_BLOCKS);
    localparam int BLK_W = ADDR_W - 4;
    localparam int TAG_W = BLK_W - IDX_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MEM_READ,
        S_UPDATE
    } state_e;

    state_e              state_q, state_d;
    logic [N_BLOCKS-1:0] valid_q, valid_d;
    logic [BLK_W-1:0]    addr_q, addr_d;
    logic [TAG_W-1:0]    tag_q  [N_BLOCKS];
    logic [127:0]        data_q [N_BLOCKS];

    logic [1:0]          pc_off;
    logic [IDX_W-1:0]    pc_idx;
    logic [TAG_W-1:0]    pc_tag;
    logic [IDX_W-1:0]    fill_idx;
    logic                hit;
    logic                fill;
    logic                unused_pc_bits;

    assign pc_off   = bus.PC[3:2];
    assign pc_idx   = bus.PC[3+IDX_W:4];
    assign pc_tag   = bus.PC[ADDR_W-1:4+IDX_W];
    assign fill_idx = addr_q[IDX_W-1:0];
    assign unused_pc_bits = ^{bus.PC[31:ADDR_W], bus.PC[1:0]};

    assign hit = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);

    assign bus.INSTRUCTION = data_q[pc_idx][{pc_off, 5'b0} +: 32];
    assign bus.MEM_ADDRESS = addr_q;

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        addr_d       = addr_q;
        fill         = 1'b0;
        bus.BUSYWAIT = 1'b0;
        bus.MEM_READ = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                bus.BUSYWAIT = !hit;
                if (!hit) begin
                    // Latch the block address so the burst is immune to PC changes.
                    addr_d  = {pc_tag, pc_idx};
                    state_d = S_MEM_READ;
                end
            end
            S_MEM_READ: begin
                bus.BUSYWAIT = 1'b1;
                bus.MEM_READ = 1'b1;
                if (!bus.MEM_BUSYWAIT) begin
                    fill              = 1'b1;
                    valid_d[fill_idx] = 1'b1;
                    state_d           = S_UPDATE;
                end
            end
            S_UPDATE: begin
                bus.BUSYWAIT = 1'b1;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // The CPU is held in reset too; never stall it or talk to memory.
        if (!RESET) begin
            bus.BUSYWAIT = 1'b0;
            bus.MEM_READ = 1'b0;
            fill         = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= S_IDLE;
            valid_q <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
        end
    end

    // Tag/data arrays carry no reset; valid bits alone gate their use.
    always_ff @(posedge CLK) begin
        if (fill) begin
            data_q[fill_idx] <= bus.MEM_READDATA;
            tag_q[fill_idx]  <= addr_q[BLK_W-1:IDX_W];
        end
    end
endmodule

// File: tb/tb_icache_fetch.sv
// Self-checking bench for icache_fetch: directed scenarios plus random fetches
// checked against a block-level cache/memory reference model.
`timescale 1ns/1ps
module tb_icache_fetch;
    logic CLK = 1'b0;
    logic RESET = 1'b0;

    icache_fetch_if #(.ADDR_W(10)) bus ();

    icache_fetch #(
        .ADDR_W  (10),
        .N_BLOCKS(8)
    ) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    logic [127:0] mem [64];
    int           line_blk [8];
    int           n_assert = 0;
    int           n_fail = 0;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [31:0] word_of(input int blk, input int off);
        logic [127:0] b;
        b = mem[blk];
        return b[off*32 +: 32];
    endfunction

    task automatic clear_model();
        foreach (line_blk[i]) line_blk[i] = -1;
    endtask

    // One CPU fetch; memory answers after m busy cycles if the model misses.
    task automatic fetch(input logic [31:0] pc, input int m);
        int blk;
        int line;
        int off;
        int n;
        bit hit;
        blk  = int'(pc[9:4]);
        line = blk % 8;
        off  = int'(pc[3:2]);
        hit  = (line_blk[line] == blk);
        bus.PC = pc;
        bus.MEM_BUSYWAIT = 1'b0;
        #1;
        chk("busy_first", bus.BUSYWAIT, !hit);
        chk("mem_read_idle", bus.MEM_READ, 1'b0);
        if (!hit) begin
            n = 0;
            step();
            while (bus.BUSYWAIT === 1'b1 && n < 64) begin
                chk("mem_read_phase", bus.MEM_READ, n <= m);
                if (n <= m) chk("mem_addr", bus.MEM_ADDRESS, blk);
                bus.MEM_BUSYWAIT = (n < m);
                bus.MEM_READDATA = (n < m) ? rand128() : mem[blk];
                n++;
                step();
            end
            chk("penalty", n, m + 2);
            line_blk[line] = blk;
        end
        chk("instr", bus.INSTRUCTION, word_of(blk, off));
        chk("busy_hit", bus.BUSYWAIT, 1'b0);
        chk("mem_read_hit", bus.MEM_READ, 1'b0);
        step();
    endtask

    initial begin
        int blk;
        logic [31:0] pc;
        foreach (mem[i]) mem[i] = rand128();
        mem[0] = 128'h33333333_22222222_11111111_00000000;
        clear_model();
        bus.PC = 32'h0;
        bus.MEM_BUSYWAIT = 1'b0;
        bus.MEM_READDATA = '0;

        // Held in reset for two cycles.
        step();
        chk("rst_busy", bus.BUSYWAIT, 1'b0);
        chk("rst_mread", bus.MEM_READ, 1'b0);
        step();
        chk("rst_busy2", bus.BUSYWAIT, 1'b0);
        chk("rst_addr", bus.MEM_ADDRESS, 6'h00);
        RESET = 1'b1;

        // Cold start and same-block hits.
        fetch(32'h0, 5);
        fetch(32'h4, 0);
        fetch(32'h8, 0);
        fetch(32'hC, 0);

        // Conflict eviction on line 0.
        fetch(32'h80, 3);
        fetch(32'h0, 2);

        // Zero-wait memory, top line, then hit on it.
        fetch(32'h3F0, 0);
        fetch(32'h3FC, 0);

        // Back-to-back misses.
        fetch(32'h10, 1);
        fetch(32'h20, 1);

        // Reset asserted between edges during a memory read.
        bus.PC = 32'h50;
        bus.MEM_BUSYWAIT = 1'b1;
        step();
        step();
        chk("mid_mread", bus.MEM_READ, 1'b1);
        chk("mid_busy", bus.BUSYWAIT, 1'b1);
        #2;
        RESET = 1'b0;
        #1;
        chk("mid_rst_mread", bus.MEM_READ, 1'b0);
        chk("mid_rst_busy", bus.BUSYWAIT, 1'b0);
        chk("mid_rst_addr", bus.MEM_ADDRESS, 6'h00);
        bus.MEM_BUSYWAIT = 1'b0;
        bus.MEM_READDATA = mem[5];
        bus.PC = 32'h0;
        step();
        step();
        RESET = 1'b1;
        clear_model();
        fetch(32'h0, 1);
        fetch(32'h50, 0);
        fetch(32'h54, 0);

        // Random fetches over 16 blocks (two per line) with junk upper bits.
        repeat (80) begin
            blk = $urandom_range(0, 15);
            pc  = ($urandom & 32'hFFFF_FC00) | (blk << 4)
                | $urandom_range(0, 15);
            fetch(pc, $urandom_range(0, 4));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/icache_fetch.md
Name: icache_fetch

Overview:
- Instruction-side responder for the CPU fetch interface: accepts the byte PC and returns the 32-bit INSTRUCTION at that address.
- Direct-mapped instruction cache between the CPU and a slow 128-bit-block instruction memory.
- Hits return in the same cycle; misses stall the CPU via BUSYWAIT while a 4-word block is fetched.

Parameters:
- ADDR_W, 10, number of PC bits used as the byte address (1 KB instruction space); upper PC bits ignored.
- N_BLOCKS, 8, number of cache lines (power of 2); index width IDX_W = log2(N_BLOCKS).

Ports:
- CLK  input  1  system clock; all state updates on posedge.
- RESET  input  1  asynchronous, active-low reset.
- PC  input  32  byte address of the requested instruction from the CPU (word aligned; PC[1:0] ignored).
- INSTRUCTION  output  32  instruction word at PC; valid only while BUSYWAIT=0.
- BUSYWAIT  output  1  1 = CPU must hold PC and must not advance.
- MEM_READ  output  1  block-read request to instruction memory.
- MEM_ADDRESS  output  ADDR_W-4  block address {tag,index} of the block being fetched.
- MEM_READDATA  input  128  fetched block; word0 in [31:0], word3 in [127:96].
- MEM_BUSYWAIT  input  1  1 = memory still servicing MEM_READ.

Behaviour:
- Address split: offset = PC[3:2] (word in block); index = PC[3+IDX_W:4]; tag = PC[ADDR_W-1:4+IDX_W] (3 bits at defaults).
- Per line: valid bit, tag, 128-bit data.
- Hit = valid[index] && tag[index]==tag.
- INSTRUCTION is combinational: word[offset] of line[index], regardless of hit.
- FSM states: IDLE, MEM_READ, UPDATE.
- IDLE:
  - BUSYWAIT = !hit; MEM_READ=0.
  - On miss, next posedge -> MEM_READ.
- MEM_READ:
  - BUSYWAIT=1; MEM_READ=1; MEM_ADDRESS = {tag,index} of the current PC, latched on entry and held stable.
  - Stay while MEM_BUSYWAIT=1.
  - On the posedge where MEM_BUSYWAIT=0: MEM_READ stays 1 in that cycle; capture MEM_READDATA into the line; set valid; write tag; -> UPDATE.
- UPDATE:
  - BUSYWAIT=1; MEM_READ=0.
  - Next posedge -> IDLE, where the access now hits and BUSYWAIT drops combinationally.
- Miss penalty: 2 + M cycles, where M = cycles MEM_BUSYWAIT is held high.
- No write path, so no dirty bits and no write-back; replacement simply overwrites the indexed line.
- RESET low, asynchronous, at any time, including mid-fetch:
  - All valid bits cleared; state=IDLE; MEM_READ=0; latched MEM_ADDRESS=0.
  - Any data returned by memory afterwards is ignored; tags and data arrays need not be reset.
- While RESET is low:
  - BUSYWAIT=0 and MEM_READ=0; INSTRUCTION don't-care.
  - The CPU's reset forces its PC to 0 concurrently.
- After release, the first fetch (PC=0) misses, because all lines are invalid.
- PC changes while BUSYWAIT=1: protocol violation. The fetch in flight still completes to its latched address; hit/miss is re-evaluated in IDLE.
- Simultaneous RESET assertion and MEM_BUSYWAIT falling: reset wins; the line is not written.
- Index wrap: addresses 16*N_BLOCKS bytes apart map to the same line and evict each other.

Test Plan:
- Cold start:
  - RESET low 2 cycles, release, PC=0x00. Required: BUSYWAIT=1 and MEM_READ=1 with MEM_ADDRESS=0x00 after 1 edge.
  - Memory returns 0x33333333_22222222_11111111_00000000 after 5 cycles. Required: BUSYWAIT falls 2 edges after data accepted; INSTRUCTION=0x00000000.
- Same-block hits: PC=0x04, 0x08, 0x0C after the above fetch. Required: BUSYWAIT=0 every cycle, INSTRUCTION=0x11111111, 0x22222222, 0x33333333, MEM_READ never asserted.
- Conflict eviction: PC=0x80 (same index 0, tag 1).
  - Required: miss with MEM_ADDRESS=0x08.
  - Then PC=0x00 misses again with MEM_ADDRESS=0x00.
- Zero-wait memory: MEM_BUSYWAIT held 0. A miss at PC=0x3F0 must fill in exactly 2 stalled cycles; line 7 is valid with tag 7.
- Reset mid-fetch: assert RESET during MEM_READ state (MEM_BUSYWAIT=1), asynchronously between edges.
  - Required: MEM_READ=0 and BUSYWAIT=0 immediately.
  - After release, PC=0 misses again (valid cleared) even if memory returned data during reset.
- Back-to-back misses: PC sequence 0x10 then 0x20, each miss. Required: two separate MEM_READ bursts, MEM_ADDRESS 0x01 then 0x02, no dropped stall cycle between them.
